sram_port_arbiter: RTL

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/tensor_core_pkg.sv | 20 ++
 rtl/rr_pick.sv | 35 +++
 rtl/sram_port_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tensor_core_pkg.sv
// Shared arbitration types and the round-robin index helper for the SRAM port arbiter.
package tensor_core_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // Index that lies offset positions after base, wrapping at n (offset is at most n).
  function automatic int rr_wrap(input int base, input int offset, input int n);
    int sum;
    sum = base + offset;
    if (sum >= n) begin
      return sum - n;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set bit of req_mask searching upward from
// last_idx+1, wrapping, with last_idx itself examined last.
module rr_pick
  import tensor_core_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_mask,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          found
);

  logic [IW-1:0] cand_s;
  logic          hit_s;

  // Walk the candidates in priority order and latch the first requesting one.
  always_comb begin
    gnt_oh  = {N{1'b0}};
    gnt_idx = {IW{1'b0}};
    found   = 1'b0;
    cand_s  = {IW{1'b0}};
    hit_s   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand_s          = IW'(rr_wrap(int'(last_idx), i, N));
      hit_s           = ~found & req_mask[cand_s];
      gnt_idx         = hit_s ? cand_s : gnt_idx;
      gnt_oh[cand_s]  = gnt_oh[cand_s] | hit_s;
      found           = found | hit_s;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM among NUM_REQ requesters with round-robin grants and
// bounded lock-based ownership; the SRAM itself lives in the parent.
module sram_port_arbiter
  import tensor_core_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LOCK   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] din,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          mem_cs,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_din,
  input  logic [DATA_WIDTH-1:0]         mem_dout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_e            state_r;
  logic [IW-1:0]         owner_r;
  logic [IW-1:0]         last_owner_r;
  logic [NUM_REQ-1:0]    gnt_r;
  logic [NUM_REQ-1:0]    rvalid_r;
  logic [CW-1:0]         lock_cnt_r;

  logic [ADDR_WIDTH-1:0] addr_a_s [NUM_REQ];
  logic [DATA_WIDTH-1:0] din_a_s  [NUM_REQ];
  logic                  beat_s;
  logic                  rd_beat_s;
  logic                  force_s;
  logic                  keep_s;
  logic [NUM_REQ-1:0]    pick_mask_s;
  logic [NUM_REQ-1:0]    pick_oh_s;
  logic [IW-1:0]         pick_idx_s;
  logic                  pick_found_s;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a_s[g] = addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign din_a_s[g]  = din[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign beat_s    = (state_r == OWNED) & req[owner_r];
  assign rd_beat_s = beat_s & ~we[owner_r];

  // The current owner is masked out, so in OWNED a hit means another requester waits.
  assign pick_mask_s = req & ~gnt_r;
  assign force_s     = (lock_cnt_r >= CW'(MAX_LOCK - 1)) & pick_found_s;
  assign keep_s      = beat_s & lock[owner_r] & ~force_s;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req_mask (pick_mask_s),
    .last_idx (last_owner_r),
    .gnt_oh   (pick_oh_s),
    .gnt_idx  (pick_idx_s),
    .found    (pick_found_s)
  );

  assign mem_cs   = beat_s;
  assign mem_we   = beat_s & we[owner_r];
  assign mem_addr = addr_a_s[owner_r];
  assign mem_din  = din_a_s[owner_r];
  assign rdata    = mem_dout;
  assign gnt      = gnt_r;
  assign rvalid   = rvalid_r;

  // Ownership FSM with registered grant, read-valid and lock-beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      owner_r      <= {IW{1'b0}};
      last_owner_r <= IW'(NUM_REQ - 1);
      gnt_r        <= {NUM_REQ{1'b0}};
      rvalid_r     <= {NUM_REQ{1'b0}};
      lock_cnt_r   <= {CW{1'b0}};
    end else begin
      rvalid_r <= rd_beat_s ? gnt_r : {NUM_REQ{1'b0}};
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            state_r      <= OWNED;
            owner_r      <= pick_idx_s;
            last_owner_r <= pick_idx_s;
            gnt_r        <= pick_oh_s;
            lock_cnt_r   <= {CW{1'b0}};
          end else begin
            gnt_r      <= {NUM_REQ{1'b0}};
            lock_cnt_r <= {CW{1'b0}};
          end
        end
        OWNED: begin
          if (keep_s) begin
            if (lock_cnt_r != CW'(MAX_LOCK)) begin
              lock_cnt_r <= lock_cnt_r + CW'(1);
            end else begin
              lock_cnt_r <= lock_cnt_r;
            end
          end else if (pick_found_s) begin
            owner_r      <= pick_idx_s;
            last_owner_r <= pick_idx_s;
            gnt_r        <= pick_oh_s;
            lock_cnt_r   <= {CW{1'b0}};
          end else begin
            state_r    <= IDLE;
            gnt_r      <= {NUM_REQ{1'b0}};
            lock_cnt_r <= {CW{1'b0}};
          end
        end
        default: begin
          state_r    <= IDLE;
          gnt_r      <= {NUM_REQ{1'b0}};
          lock_cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule
